// File: rtl/serial_program_loader_pkg.sv
// Shared types and constants for the serial program loader.
package serial_program_loader_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        LATCH,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/serial_program_loader_if.sv
// Loader-side bus: shift register strobe/bit/parallel word and instruction memory write port.
interface serial_program_loader_if #(
    parameter int unsigned ADDR_W = 15
);
    import serial_program_loader_pkg::*;

    logic              shift_bit;
    logic              shift_en;
    logic [WORD_W-1:0] word;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport master (
        output shift_bit,
        output shift_en,
        input  word,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  shift_bit,
        input  shift_en,
        output word,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/serial_program_loader_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with single-cycle rise/fall pulses.
module serial_program_loader_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetb,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level_d1;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_sync     <= '0;
            r_level_d1 <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_level_d1 <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_level_d1;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_level_d1;

endmodule

// File: rtl/serial_program_loader.sv
// Program download controller: serial stream -> shift register -> instruction memory,
// holding the CPU in reset while a download is active.
module serial_program_loader
    import serial_program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           resetb,
    input  logic                           sck_i,
    input  logic                           sdi_i,
    input  logic                           csb_i,
    serial_program_loader_if.master        bus,
    output logic                           cpu_hold_o,
    output logic                           done_o,
    output logic                           partial_o,
    output logic                           overflow_o
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ADDR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic w_sck_s, w_sck_rise, w_sck_fall_unused;
    logic w_csb_s, w_csb_rise, w_csb_fall;
    logic w_sdi_s, w_sdi_rise_unused, w_sdi_fall_unused;

    serial_program_loader_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk     (clk),
        .resetb  (resetb),
        .i_async (sck_i),
        .o_level (w_sck_s),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall_unused)
    );

    serial_program_loader_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csb (
        .clk     (clk),
        .resetb  (resetb),
        .i_async (csb_i),
        .o_level (w_csb_s),
        .o_rise  (w_csb_rise),
        .o_fall  (w_csb_fall)
    );

    serial_program_loader_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk     (clk),
        .resetb  (resetb),
        .i_async (sdi_i),
        .o_level (w_sdi_s),
        .o_rise  (w_sdi_rise_unused),
        .o_fall  (w_sdi_fall_unused)
    );

    logic w_sck_level_unused;
    assign w_sck_level_unused = w_sck_s;

    loader_state_t   r_state, w_state_nx;
    logic [3:0]      r_bit_cnt, w_bit_cnt_nx;
    logic [ADDR_W:0] r_addr, w_addr_nx;
    logic            r_end_pending, w_end_pending_nx;
    logic            r_cpu_hold, w_cpu_hold_nx;
    logic            r_done, w_done_nx;
    logic            r_partial, w_partial_nx;
    logic            r_overflow, w_overflow_nx;
    logic            w_shift_en, w_shift_bit, w_wr_en;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_addr        <= '0;
            r_end_pending <= 1'b0;
            r_cpu_hold    <= 1'b0;
            r_done        <= 1'b0;
            r_partial     <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_bit_cnt     <= w_bit_cnt_nx;
            r_addr        <= w_addr_nx;
            r_end_pending <= w_end_pending_nx;
            r_cpu_hold    <= w_cpu_hold_nx;
            r_done        <= w_done_nx;
            r_partial     <= w_partial_nx;
            r_overflow    <= w_overflow_nx;
        end
    end

    always_comb begin
        w_state_nx       = r_state;
        w_bit_cnt_nx     = r_bit_cnt;
        w_addr_nx        = r_addr;
        w_end_pending_nx = r_end_pending;
        w_cpu_hold_nx    = r_cpu_hold;
        w_done_nx        = r_done;
        w_partial_nx     = r_partial;
        w_overflow_nx    = r_overflow;
        w_shift_en       = 1'b0;
        w_shift_bit      = 1'b0;
        w_wr_en          = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (w_csb_fall) begin
                    w_state_nx       = RECV;
                    w_bit_cnt_nx     = '0;
                    w_addr_nx        = '0;
                    w_end_pending_nx = 1'b0;
                    w_cpu_hold_nx    = 1'b1;
                    w_done_nx        = 1'b0;
                    w_partial_nx     = 1'b0;
                    w_overflow_nx    = 1'b0;
                end
            end
            RECV: begin
                if (w_csb_rise) begin
                    w_state_nx    = DONE;
                    w_cpu_hold_nx = 1'b0;
                    w_bit_cnt_nx  = '0;
                    if (r_bit_cnt == 4'd0) begin
                        w_done_nx = 1'b1;
                    end else begin
                        w_done_nx    = 1'b0;
                        w_partial_nx = 1'b1;
                    end
                end else if (w_sck_rise && !w_csb_s) begin
                    w_shift_en  = 1'b1;
                    w_shift_bit = w_sdi_s;
                    if (r_bit_cnt == 4'd15) begin
                        w_bit_cnt_nx = '0;
                        w_state_nx   = LATCH;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 4'd1;
                    end
                end
            end
            // the shift register output lags the 16th strobe by one cycle
            LATCH: begin
                w_state_nx = WRITE;
                if (w_csb_rise) begin
                    w_end_pending_nx = 1'b1;
                end
            end
            WRITE: begin
                if (r_addr < MAX_WORDS) begin
                    w_wr_en   = 1'b1;
                    w_addr_nx = r_addr + ADDR_ONE;
                end else begin
                    w_overflow_nx = 1'b1;
                end
                // a chip-select release seen during LATCH/WRITE ends the download after this write
                if (w_csb_rise || r_end_pending) begin
                    w_state_nx       = DONE;
                    w_done_nx        = 1'b1;
                    w_cpu_hold_nx    = 1'b0;
                    w_end_pending_nx = 1'b0;
                end else begin
                    w_state_nx = RECV;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign bus.shift_en  = w_shift_en;
    assign bus.shift_bit = w_shift_bit;
    assign bus.wr_en     = w_wr_en;
    assign bus.wr_addr   = r_addr[ADDR_W-1:0];
    assign bus.wr_data   = w_wr_en ? bus.word : '0;

    assign cpu_hold_o = r_cpu_hold;
    assign done_o     = r_done;
    assign partial_o  = r_partial;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_serial_program_loader.sv
// Drives two loaders (ADDR_W=15 and ADDR_W=2) with the same serial stream and checks
// writes, strobes and flags against a word-level model of each download.
module tb_serial_program_loader;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic sck = 1'b0;
    logic sdi = 1'b0;
    logic csb = 1'b0;

    always #5 clk = ~clk;

    serial_program_loader_if #(.ADDR_W(15)) bus_b ();
    serial_program_loader_if #(.ADDR_W(2))  bus_s ();

    logic hold_b, done_b, part_b, ovf_b;
    logic hold_s, done_s, part_s, ovf_s;

    serial_program_loader #(.ADDR_W(15), .SYNC_STAGES(2)) dut_big (
        .clk        (clk),
        .resetb     (resetb),
        .sck_i      (sck),
        .sdi_i      (sdi),
        .csb_i      (csb),
        .bus        (bus_b),
        .cpu_hold_o (hold_b),
        .done_o     (done_b),
        .partial_o  (part_b),
        .overflow_o (ovf_b)
    );

    serial_program_loader #(.ADDR_W(2), .SYNC_STAGES(2)) dut_small (
        .clk        (clk),
        .resetb     (resetb),
        .sck_i      (sck),
        .sdi_i      (sdi),
        .csb_i      (csb),
        .bus        (bus_s),
        .cpu_hold_o (hold_s),
        .done_o     (done_s),
        .partial_o  (part_s),
        .overflow_o (ovf_s)
    );

    // external 16-bit shift registers, one per loader
    logic [15:0] sr_b = '0;
    logic [15:0] sr_s = '0;
    always @(posedge clk) begin
        if (bus_b.shift_en) sr_b <= {sr_b[14:0], bus_b.shift_bit};
        if (bus_s.shift_en) sr_s <= {sr_s[14:0], bus_s.shift_bit};
    end
    assign bus_b.word = sr_b;
    assign bus_s.word = sr_s;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // monitor state per loader (0 = big, 1 = small)
    int unsigned n_strobe [2];
    int unsigned n_wr     [2];
    int unsigned last16   [2];
    int unsigned lat_err  [2];
    int unsigned excl_err [2];
    logic        prev_se  [2];
    logic        prev_we  [2];
    logic        cap      [2][128];
    logic [14:0] wa_log   [2][16];
    logic [15:0] wd_log   [2][16];

    task automatic clear_mon();
        for (int d = 0; d < 2; d++) begin
            n_strobe[d] = 0;
            n_wr[d]     = 0;
            last16[d]   = 0;
            lat_err[d]  = 0;
            excl_err[d] = 0;
            prev_se[d]  = 1'b0;
            prev_we[d]  = 1'b0;
        end
    endtask

    task automatic mon(input int d, input logic se, input logic sb, input logic we,
                       input logic [14:0] wa, input logic [15:0] wd);
        if (se) begin
            if (n_strobe[d] < 128) cap[d][n_strobe[d]] = sb;
            n_strobe[d]++;
            if (n_strobe[d] % 16 == 0) last16[d] = cyc;
        end
        if (we) begin
            if (cyc - last16[d] != 2) lat_err[d]++;
            if (n_wr[d] < 16) begin
                wa_log[d][n_wr[d]] = wa;
                wd_log[d][n_wr[d]] = wd;
            end
            n_wr[d]++;
        end
        if ((se && we) || (se && prev_se[d]) || (we && prev_we[d])) excl_err[d]++;
        prev_se[d] = se;
        prev_we[d] = we;
    endtask

    always @(negedge clk) begin
        mon(0, bus_b.shift_en, bus_b.shift_bit, bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data);
        mon(1, bus_s.shift_en, bus_s.shift_bit, bus_s.wr_en, 15'(bus_s.wr_addr), bus_s.wr_data);
    end

    function automatic logic [31:0] flags(input int d);
        logic [3:0] f;
        f = (d == 0) ? {hold_b, done_b, part_b, ovf_b} : {hold_s, done_s, part_s, ovf_s};
        return {28'd0, f};
    endfunction

    // stimulus bit stream for the current download, MSB of each word first
    logic        sent [128];
    int unsigned n_sent;

    task automatic push_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            sent[n_sent] = w[i];
            n_sent++;
        end
    endtask

    task automatic push_bits(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            sent[n_sent] = 1'($urandom_range(0, 1));
            n_sent++;
        end
    endtask

    function automatic logic [15:0] model_word(input int unsigned idx);
        logic [15:0] w;
        w = '0;
        for (int unsigned j = 0; j < 16; j++) w = {w[14:0], sent[idx * 16 + j]};
        return w;
    endfunction

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sdi = b;
        wait_clk(4);
        sck = 1'b1;
        wait_clk(4);
        sck = 1'b0;
    endtask

    task automatic check_dl(input string name);
        int unsigned nw, rem, m, expw, bmis;
        logic [3:0] ef;
        nw  = n_sent / 16;
        rem = n_sent % 16;
        for (int d = 0; d < 2; d++) begin
            m    = (d == 0) ? 32768 : 4;
            expw = (nw < m) ? nw : m;
            check($sformatf("%s_strobes%0d", name, d), n_strobe[d], n_sent);
            bmis = 0;
            for (int unsigned i = 0; i < n_sent && i < 128; i++)
                if (cap[d][i] !== sent[i]) bmis++;
            check($sformatf("%s_bits%0d", name, d), bmis, 0);
            check($sformatf("%s_nwr%0d", name, d), n_wr[d], expw);
            for (int unsigned i = 0; i < expw && i < 16; i++) begin
                check($sformatf("%s_addr%0d_%0d", name, d, i), 32'(wa_log[d][i]), i);
                check($sformatf("%s_data%0d_%0d", name, d, i), 32'(wd_log[d][i]), 32'(model_word(i)));
            end
            check($sformatf("%s_latency%0d", name, d), lat_err[d], 0);
            check($sformatf("%s_excl%0d", name, d), excl_err[d], 0);
            ef = {1'b0, rem == 0, rem != 0, nw > m};
            check($sformatf("%s_flags%0d", name, d), flags(d), {28'd0, ef});
        end
    endtask

    // early: on the last bit, raise chip select while sck is still high
    task automatic run_dl(input string name, input bit early);
        clear_mon();
        csb = 1'b0;
        wait_clk(6);
        for (int unsigned i = 0; i < n_sent; i++) begin
            if (early && i == n_sent - 1) begin
                sdi = sent[i];
                wait_clk(4);
                sck = 1'b1;
                wait_clk($urandom_range(3, 5));
                csb = 1'b1;
                wait_clk(6);
                sck = 1'b0;
                wait_clk(4);
            end else begin
                send_bit(sent[i]);
            end
            if (i == 0) begin
                check($sformatf("%s_busy0", name), flags(0), 32'h8);
                check($sformatf("%s_busy1", name), flags(1), 32'h8);
            end
        end
        if (!(early && n_sent > 0)) begin
            wait_clk(4);
            csb = 1'b1;
        end
        wait_clk(12);
        check_dl(name);
    endtask

    initial begin
        int unsigned nw, rem;
        logic [15:0] w2;
        bit early;

        // reset with chip select low and sck toggling
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            sck = ~sck;
            wait_clk(4);
        end
        sck = 1'b0;
        check("rst_flags0", flags(0), 0);
        check("rst_flags1", flags(1), 0);
        check("rst_strobes", n_strobe[0] + n_strobe[1], 0);
        check("rst_writes", n_wr[0] + n_wr[1], 0);
        check("rst_addr", 32'(bus_b.wr_addr), 0);
        check("rst_data", 32'(bus_b.wr_data), 0);
        resetb = 1'b1;
        wait_clk(10);
        check("csb_low_after_rst", flags(0), 0);
        csb = 1'b1;
        wait_clk(10);

        n_sent = 0;
        push_word(16'hA5C3);
        run_dl("one", 1'b0);

        n_sent = 0;
        push_word(16'h0001);
        push_word(16'hFFFF);
        push_word(16'h8000);
        run_dl("burst", 1'b0);

        n_sent = 0;
        push_word(16'h1234);
        push_bits(7);
        run_dl("partial", 1'b0);

        n_sent = 0;
        for (int i = 0; i < 5; i++) push_word(16'($urandom));
        run_dl("ovf", 1'b1);

        // reset 9 bits into the second word, then a fresh download
        n_sent = 0;
        w2 = 16'($urandom);
        push_word(w2);
        push_bits(9);
        clear_mon();
        csb = 1'b0;
        wait_clk(6);
        for (int unsigned i = 0; i < n_sent; i++) send_bit(sent[i]);
        wait_clk(4);
        check("abort_nwr0", n_wr[0], 1);
        check("abort_data0", 32'(wd_log[0][0]), 32'(w2));
        resetb = 1'b0;
        wait_clk(2);
        check("midrst_flags0", flags(0), 0);
        check("midrst_flags1", flags(1), 0);
        resetb = 1'b1;
        wait_clk(4);
        csb = 1'b1;
        wait_clk(10);
        n_sent = 0;
        push_word(16'hBEEF);
        run_dl("beef", 1'b0);

        for (int k = 0; k < 6; k++) begin
            n_sent = 0;
            nw  = $urandom_range(0, 6);
            rem = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 15);
            for (int unsigned i = 0; i < nw; i++) push_word(16'($urandom));
            push_bits(rem);
            early = ($urandom_range(0, 1) == 1);
            run_dl($sformatf("rnd%0d", k), early);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
